// File: rtl/cpu_checker_pkg.sv
// Shared definitions for the trace-record checker: FSM state encoding,
// output format codes, field length limits and the ASCII punctuation it matches.
package cpu_checker_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TIME,
        S_PC,
        S_COLON,
        S_SP1,
        S_REG,
        S_ADDR,
        S_SP2,
        S_LT,
        S_SP3,
        S_DATA,
        S_DONE_REG,
        S_DONE_MEM
    } state_t;

    localparam logic [1:0] FMT_NONE = 2'b00;
    localparam logic [1:0] FMT_REG  = 2'b01;
    localparam logic [1:0] FMT_MEM  = 2'b10;

    localparam logic [3:0] DEC_MAX = 4'd4;
    localparam logic [3:0] HEX_MAX = 4'd8;

    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3a;
    localparam logic [7:0] CH_LT     = 8'h3c;
    localparam logic [7:0] CH_EQ     = 8'h3d;
    localparam logic [7:0] CH_STAR   = 8'h2a;

    // Moore decode: only the two terminal states report a record.
    function automatic logic [1:0] fmt_of_state(input state_t s);
        logic [1:0] f;
        f = FMT_NONE;
        if (s == S_DONE_REG) f = FMT_REG;
        if (s == S_DONE_MEM) f = FMT_MEM;
        return f;
    endfunction

endpackage

// File: rtl/cpu_checker_char_class.sv
// Combinational ASCII classifier shared by every parse state.
module char_class (
    input  logic [7:0] char,
    output logic       is_dec,
    output logic       is_hex_lc,
    output logic       is_space,
    output logic       is_caret,
    output logic       is_hash,
    output logic       is_body_sym
);

    // Hex digits are lowercase only; 'A'-'F' deliberately fall through as errors.
    assign is_dec      = (char >= 8'h30) && (char <= 8'h39);
    assign is_hex_lc   = is_dec || ((char >= 8'h61) && (char <= 8'h66));
    assign is_space    = (char == 8'h20);
    assign is_caret    = (char == 8'h5e);
    assign is_hash     = (char == 8'h23);
    assign is_body_sym = (char == 8'h24) || (char == 8'h2a);

endmodule

// File: rtl/cpu_checker.sv
// Streaming checker for '^TIME@PC: BODY <= DATA#' trace records; pulses
// format_type for one cycle after a well-formed record's closing '#'.
module cpu_checker
    import cpu_checker_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] char,
    output logic [1:0] format_type
);

    logic is_dec;
    logic is_hex_lc;
    logic is_space;
    logic is_caret;
    logic is_hash;
    logic is_body_sym;

    char_class u_char_class (
        .char        (char),
        .is_dec      (is_dec),
        .is_hex_lc   (is_hex_lc),
        .is_space    (is_space),
        .is_caret    (is_caret),
        .is_hash     (is_hash),
        .is_body_sym (is_body_sym)
    );

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic       mem_body;
    logic       mem_body_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            mem_body <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            mem_body <= mem_body_next;
        end
    end

    // Any character not explicitly accepted below falls back to IDLE with a
    // cleared counter; '^' overrides every state and restarts the record.
    always_comb begin
        state_next    = S_IDLE;
        cnt_next      = 4'd0;
        mem_body_next = mem_body;
        if (is_caret) begin
            state_next = S_TIME;
        end else begin
            case (state)
                S_TIME: begin
                    if (is_dec && (cnt < DEC_MAX)) begin
                        state_next = S_TIME;
                        cnt_next   = cnt + 4'd1;
                    end else if ((char == CH_AT) && (cnt != 4'd0)) begin
                        state_next = S_PC;
                    end
                end
                S_PC: begin
                    if (is_hex_lc && (cnt < HEX_MAX)) begin
                        state_next = S_PC;
                        cnt_next   = cnt + 4'd1;
                    end else if ((char == CH_COLON) && (cnt == HEX_MAX)) begin
                        state_next = S_COLON;
                    end
                end
                S_COLON, S_SP1: begin
                    if (is_space) begin
                        state_next = S_SP1;
                    end else if (is_body_sym) begin
                        mem_body_next = (char == CH_STAR);
                        state_next    = (char == CH_STAR) ? S_ADDR : S_REG;
                    end
                end
                S_REG: begin
                    if (is_dec && (cnt < DEC_MAX)) begin
                        state_next = S_REG;
                        cnt_next   = cnt + 4'd1;
                    end else if (cnt != 4'd0) begin
                        if (is_space)            state_next = S_SP2;
                        else if (char == CH_LT)  state_next = S_LT;
                    end
                end
                S_ADDR: begin
                    if (is_hex_lc && (cnt < HEX_MAX)) begin
                        state_next = S_ADDR;
                        cnt_next   = cnt + 4'd1;
                    end else if (cnt == HEX_MAX) begin
                        if (is_space)            state_next = S_SP2;
                        else if (char == CH_LT)  state_next = S_LT;
                    end
                end
                S_SP2: begin
                    if (is_space)            state_next = S_SP2;
                    else if (char == CH_LT)  state_next = S_LT;
                end
                S_LT: begin
                    if (char == CH_EQ) state_next = S_SP3;
                end
                S_SP3: begin
                    if (is_space) begin
                        state_next = S_SP3;
                    end else if (is_hex_lc) begin
                        state_next = S_DATA;
                        cnt_next   = 4'd1;
                    end
                end
                S_DATA: begin
                    if (is_hex_lc && (cnt < HEX_MAX)) begin
                        state_next = S_DATA;
                        cnt_next   = cnt + 4'd1;
                    end else if (is_hash && (cnt == HEX_MAX)) begin
                        state_next = mem_body ? S_DONE_MEM : S_DONE_REG;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    assign format_type = fmt_of_state(state);

endmodule

// File: tb/tb_cpu_checker.sv
// Directed bench for cpu_checker: feeds record strings one character per
// cycle and checks format_type after every sampled character.
module tb_cpu_checker;

    logic       clk;
    logic       reset;
    logic [7:0] char;
    logic [1:0] format_type;

    int tests_run;
    int tests_failed;

    cpu_checker dut (
        .clk         (clk),
        .reset       (reset),
        .char        (char),
        .format_type (format_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [1:0] got, input logic [1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive one character before the edge, sample #1 after it.
    task automatic send_char(input logic [7:0] c);
        @(negedge clk);
        char = c;
        @(posedge clk);
        #1;
    endtask

    // Every character of s must leave format_type at 00 except the last,
    // which must produce exp_last.
    task automatic send_record(input string tag, input string s, input logic [1:0] exp_last);
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i]);
            check_eq($sformatf("%s[%0d]", tag, i), format_type,
                     (i == s.len() - 1) ? exp_last : 2'b00);
        end
    endtask

    task automatic send_idle(input string tag);
        send_char(8'h78);
        check_eq(tag, format_type, 2'b00);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        char         = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_state", format_type, 2'b00);
        @(negedge clk);
        reset = 1'b1;

        // Basic register and memory records, then the pulse must drop.
        send_record("reg_basic", "^242@000030f4: $31 <=12345678#", 2'b01);
        send_idle("reg_basic_after");
        send_record("mem_basic", "^338@00003130: *00000088 <= ffffb528#", 2'b10);
        send_idle("mem_basic_after");

        // Uppercase hex anywhere in DATA is rejected.
        send_record("mem_upper0", "^338@00003130: *00000088 <= Ffffb528#", 2'b00);
        send_record("mem_upper4", "^338@00003130: *00000088 <= ffffB528#", 2'b00);

        // Field length boundaries.
        send_record("time5", "^24222@000030f4: $31 <=12345678#", 2'b00);
        send_record("data_empty", "^242@000030f4: $31 <=#", 2'b00);
        send_record("data6_sp", "^242@000030f4: $31 <=   123215 #", 2'b00);
        send_record("data10", "^338@00003130: *00000088 <= ffffb52812#", 2'b00);
        send_record("data_trail_sp", "^242@000030f4: $31 <=12345678 #", 2'b00);
        send_record("reg5", "^242@000030f4: $31234 <=12345678#", 2'b00);
        send_record("reg_empty", "^242@000030f4: $ <=12345678#", 2'b00);
        send_record("pc7", "^242@00030f4: $31 <=12345678#", 2'b00);
        send_record("addr9", "^1@00003130:*000000881<=ffffb528#", 2'b00);
        send_record("lt_split", "^242@000030f4: $31 < =12345678#", 2'b00);
        send_record("pc_upper", "^242@000030F4: $31 <=12345678#", 2'b00);

        // Maximum-length fields and zero spaces are legal.
        send_record("time4_reg4", "^9999@deadbeef:  $1234   <=   00000000#", 2'b01);
        send_record("nospace_mem", "^1@abcdef01:*0123abcd<=89abcdef#", 2'b10);
        send_idle("nospace_mem_after");

        // A partial record interrupted by '^' restarts cleanly.
        send_record("restart", "^242@0000^242@000030f4: $31 <=12345678#", 2'b01);
        send_idle("restart_after");

        // Reset mid-record discards everything seen so far.
        send_record("pre_reset", "^242@000030f4: $3", 2'b00);
        @(negedge clk);
        reset = 1'b0;
        char  = 8'h00;
        @(posedge clk);
        #1;
        check_eq("mid_reset", format_type, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        send_record("post_reset_tail", "1 <=12345678#", 2'b00);
        send_record("post_reset_fresh", "^338@00003130: *00000088 <= ffffb528#", 2'b10);

        // Back-to-back records: one pulse per '#', the next '^' clears it.
        send_record("b2b_0", "^1@00000000:$0<=00000000#", 2'b01);
        send_record("b2b_1", "^2@00000001:*00000002<=00000003#", 2'b10);
        send_record("b2b_2", "^3@00000004:$5<=00000006#", 2'b01);
        send_idle("b2b_after");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cpu_checker.md
CPU_CHECKER -- requirements
Module: cpu_checker

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: reset  input  1  reset, synchronous, active-low; clock clk.
REQ-003 SHALL have port: char  input  8  ASCII character, one sampled per rising clk edge.
REQ-004 SHALL have port: format_type  output  2  00 = no valid record; 01 = register-write record; 10 = memory-write record.
REQ-005 SHALL have no parameters.

Function
REQ-006 SHALL parse a record of the form: '^' TIME '@' PC ':' SP* BODY SP* '<=' SP* DATA '#'.
REQ-007 SHALL define the fields as follows.
- TIME: 1-4 decimal digits.
- PC: exactly 8 hex digits.
- DATA: exactly 8 hex digits.
- SP*: zero or more ASCII spaces (0x20).
REQ-008 SHALL accept two BODY forms.
- Register body: '$' followed by 1-4 decimal digits; yields format 01.
- Memory body: '*' followed by exactly 8 hex digits; yields format 10.
REQ-009 SHALL accept as hex digits only '0'-'9' and lowercase 'a'-'f'; uppercase 'A'-'F' is an error.
REQ-010 SHALL treat '<=' as two adjacent characters with no space between them.
REQ-011 SHALL require '#' immediately after the 8th DATA digit; a trailing space or any extra digit is an error.
REQ-012 SHALL use these FSM states.
- IDLE.
- TIME (digit counter 0-4).
- PC (hex counter 0-8).
- COLON.
- SP1.
- REG (counter 0-4).
- ADDR (counter 0-8).
- SP2.
- LT.
- SP3.
- DATA (counter 0-8).
- DONE_REG.
- DONE_MEM.
REQ-013 SHALL move to IDLE on any character that violates the grammar, and stay in IDLE until '^' arrives.
REQ-014 SHALL restart parsing when '^' is received in any state: enter TIME with the counter cleared.
REQ-015 SHALL treat a field that exceeds its maximum length (for example, a 5-digit TIME) as an error, not as a wrap.
REQ-016 SHALL enter DONE_REG or DONE_MEM on the clk edge that samples a valid closing '#'.
REQ-017 SHALL decode format_type from the state register only (Moore output).
- DONE_REG gives 01.
- DONE_MEM gives 10.
- Every other state gives 00.
REQ-018 SHALL therefore drive format_type nonzero for exactly the one cycle after '#' is sampled.
REQ-019 SHALL treat DONE_REG and DONE_MEM like IDLE for the next character: '^' starts a new record; anything else leads to IDLE.
REQ-020 SHALL size each field counter at 4 bits and check it against 4 or 8; the counter SHALL never overflow.

Reset
REQ-021 SHALL, when reset==0 at a rising clk edge, enter IDLE, clear all counters, and drive format_type=00 from the next cycle.
REQ-022 SHALL, on reset asserted mid-record, discard the partial record; a later '#' without a new '^' gives 00.

Structure
REQ-023 SHALL place the state encoding enum and the format codes (FMT_NONE=00, FMT_REG=01, FMT_MEM=10) in a shared package cpu_checker_pkg.
REQ-024 SHALL use one combinational sub-module, char_class, that outputs is_dec, is_hex_lc, is_space, is_caret, is_hash and is_body_sym for a given char.

Verification
REQ-025 SHALL cover: "^242@000030f4: $31 <=12345678#" -> format_type=01 on the cycle after '#', then 00.
REQ-026 SHALL cover: "^338@00003130: *00000088 <= ffffb528#" -> 10; the same record with "Ffffb528" or "ffffB528" -> 00.
REQ-027 SHALL cover: "^24222@..." (5-digit TIME), "<=#" (empty DATA), "<=   123215 #" (6 digits) and "ffffb52812#" (10 digits) -> 00 in every case.
REQ-028 SHALL cover: a partial record interrupted by '^', followed by a complete valid register record -> 01 for exactly one cycle.
REQ-029 SHALL cover: reset=0 asserted mid-record, then released, then the remaining characters and '#' -> 00; a fresh valid record afterwards -> correct code.
REQ-030 SHALL cover: back-to-back valid records with no idle gap -> format_type pulses once per '#', with no merged or missed pulse.
